impresora_multitinta: RTL and testbench
=======================================

// Module: impresora_multitinta
// PURPOSE
//  Parametrised printer/scanner controller: next generation of the senales block.
//  Adds N ink channels with level counters, multi-page print jobs with per-page timing, and selectable scan duration.
//  Adds an out-of-ink stall that resumes on refill, plus decimal 7-segment readout of pages remaining.
//  Sits between the front-panel inputs and the print/scan mechanism and display drivers.
// PARAMETERS
//  CHANNELS   4   ink channels; ch0 = black, ch1..CHANNELS-1 = colour (CHANNELS>=2)
//  LEVEL_W    3   ink level counter width; full = all-ones (page units)
//  PAGE_W     4   width of paginas / pages-remaining counter (PAGE_W<=6)
//  PAGE_CYC   4   clock cycles to print one page (>=1)
//  SCAN_BASE  2   scan length in cycles for ajustes_escaner=0
// PORTS
//  clk              in   1         system clock, rising edge
//  reset            in   1         asynchronous, active-low reset
//  prendido         in   1         power switch; 0 forces OFF
//  imprimir         in   1         print request, sampled in IDLE only
//  escanear         in   1         scan request, sampled in IDLE only
//  color            in   1         job type: 0 black (ch0), 1 colour (ch1..N-1)
//  paginas          in   PAGE_W    page count, latched with imprimir
//  ajustes_escaner  in   2         scan quality; scan length = SCAN_BASE<<ajustes
//  rellenar         in   CHANNELS  per-channel refill, level := full
//  esc_escaner      out  1         high while in SCAN
//  imprimiendo      out  1         high while in PRINT
//  error_tinta      out  1         high while in ERR_INK
//  fin              out  1         one-cycle pulse on job (print or scan) completion
//  fin_tinta        out  CHANNELS  bit i high when level[i]==0
//  display1         out  7         tens digit, [0:6]=segments a..g, active-high
//  display2         out  7         units digit, same encoding
// BEHAVIOUR
//  - Reset (reset=0, async): state OFF; all outputs 0; displays blank (7'b0); levels=full; counters 0.
//  - States: OFF, IDLE, SCAN, PRINT, ERR_INK, DONE.
//  - OFF -> IDLE when prendido=1. prendido=0 in any state -> OFF next edge; active job aborted.
//    Levels are retained on power-off; fin does not pulse.
//  - IDLE: imprimir=1 and paginas!=0 -> latch paginas into rem, latch color.
//    Then go to PRINT if all required channels are nonzero, else ERR_INK.
//    imprimir with paginas=0 is ignored. Otherwise escanear=1 -> SCAN, scan counter := SCAN_BASE<<ajustes_escaner.
//    Simultaneous imprimir+escanear: print wins. Requests in any other state are ignored (not queued).
//  - SCAN: stay exactly SCAN_BASE<<ajustes cycles, then DONE. No ink use. ajustes changes mid-scan have no effect.
//  - PRINT: page counter counts PAGE_CYC cycles. At the last cycle edge: rem-=1, each required channel level-=1.
//    Then rem==0 -> DONE; else recheck ink -> PRINT (next page) or ERR_INK.
//  - Required channels: color=0 -> {ch0}; color=1 -> {ch1..CHANNELS-1}.
//  - ERR_INK: holds rem and color. Leaves to PRINT (new page, counter restarted) the cycle after all required levels are nonzero.
//  - DONE: one cycle, fin=1, then IDLE.
//  - Refill: rellenar[i] in any state except reset sets level[i]:=full next edge.
//    Refill beats same-edge decrement. Levels never wrap below 0 (checked before each page).
//  - fin_tinta is combinational from the levels, valid in every state.
//  - Displays: OFF blank. IDLE/SCAN/DONE show 00.
//    PRINT shows rem as decimal tens/units, updated the same edge rem changes.
//    ERR_INK: display1='E' (1001111), display2 = digit of lowest-index empty required channel.
//  - Digit codes: 0=1111110 1=0110000 2=1101101 3=1111001 4=0110011 5=1011011 6=1011111 7=1110000 8=1111111 9=1111011.
// TESTING
//  1 Reset low mid-PRINT -> next observation state OFF, all outputs 0, levels full, fin_tinta=0.
//  2 Defaults: color=0, paginas=3, imprimir 1 cycle -> imprimiendo 12 cycles.
//    Display shows 03,02,01; fin pulses once; level0 7->4.
//  3 ajustes_escaner=3, escanear pulse -> esc_escaner high exactly 16 cycles, then fin one cycle; levels unchanged.
//  4 level0=1, paginas=2, color=0 -> page 1 completes, fin_tinta[0]=1, ERR_INK, display 'E','0'.
//    rellenar[0] pulse -> PRINT resumes, display 01, fin after 4 more cycles.
//  5 imprimir+escanear same cycle -> PRINT entered, esc_escaner stays 0. imprimir with paginas=0 -> stays IDLE.
//  6 prendido=0 during SCAN -> OFF next edge, no fin. prendido=1 -> IDLE, displays 00.

Source files
------------

// File: rtl/impresora_multitinta.sv
// Printer/scanner controller: N ink channels with level counters, paginated print
// jobs, selectable scan length, out-of-ink stall and decimal 7-segment readout.
`timescale 1ns/1ps
module impresora_multitinta #(
   parameter int unsigned CHANNELS  = 4,
   parameter int unsigned LEVEL_W   = 3,
   parameter int unsigned PAGE_W    = 4,
   parameter int unsigned PAGE_CYC  = 4,
   parameter int unsigned SCAN_BASE = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                prendido,
   input  logic                imprimir,
   input  logic                escanear,
   input  logic                color,
   input  logic [PAGE_W-1:0]   paginas,
   input  logic [1:0]          ajustes_escaner,
   input  logic [CHANNELS-1:0] rellenar,
   output logic                esc_escaner,
   output logic                imprimiendo,
   output logic                error_tinta,
   output logic                fin,
   output logic [CHANNELS-1:0] fin_tinta,
   output logic [0:6]          display1,
   output logic [0:6]          display2
);

   localparam int unsigned SCAN_MAX = SCAN_BASE << 3;
   localparam int unsigned SCAN_W   = $clog2(SCAN_MAX + 1);
   localparam int unsigned PG_W     = (PAGE_CYC > 1) ? $clog2(PAGE_CYC) : 1;
   localparam logic [LEVEL_W-1:0] FULL    = '1;
   localparam logic [PG_W-1:0]    PG_LAST = PG_W'(PAGE_CYC - 1);
   localparam logic [6:0]         SEG_E   = 7'b1001111;

   typedef enum logic [2:0] {S_OFF, S_IDLE, S_SCAN, S_PRINT, S_ERR, S_DONE} state_t;

   state_t                             state_q, state_d;
   logic [PAGE_W-1:0]                  rem_q, rem_d;
   logic                               color_q, color_d;
   logic [PG_W-1:0]                    pg_q, pg_d;
   logic [SCAN_W-1:0]                  scan_q, scan_d;
   logic [CHANNELS-1:0][LEVEL_W-1:0]   level_q, level_d;
   logic                               page_end;
   logic                               esc_q, imp_q, err_q, fin_q;
   logic [0:6]                         disp1_q, disp1_d, disp2_q, disp2_d;
   logic [3:0]                         tens, units, empty_idx;
   logic                               empty_found;

   function automatic logic is_req(input logic c, input int unsigned i);
      return c ? (i != 0) : (i == 0);
   endfunction

   function automatic logic ink_ok(input logic c,
                                   input logic [CHANNELS-1:0][LEVEL_W-1:0] lv);
      logic ok;
      ok = 1'b1;
      for (int unsigned i = 0; i < CHANNELS; i++)
         if (is_req(c, i) && lv[i] == '0) ok = 1'b0;
      return ok;
   endfunction

   function automatic logic [6:0] seg(input logic [3:0] d);
      case (d)
         4'd0:    seg = 7'b1111110;
         4'd1:    seg = 7'b0110000;
         4'd2:    seg = 7'b1101101;
         4'd3:    seg = 7'b1111001;
         4'd4:    seg = 7'b0110011;
         4'd5:    seg = 7'b1011011;
         4'd6:    seg = 7'b1011111;
         4'd7:    seg = 7'b1110000;
         4'd8:    seg = 7'b1111111;
         4'd9:    seg = 7'b1111011;
         default: seg = 7'b0000000;
      endcase
   endfunction

   assign page_end = prendido && (state_q == S_PRINT) && (pg_q == PG_LAST);

   // Ink levels: page-end decrement on required channels, refill overrides it
   always_comb begin
      level_d = level_q;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (page_end && is_req(color_q, i) && level_q[i] != '0)
            level_d[i] = level_q[i] - 1'b1;
         if (rellenar[i])
            level_d[i] = FULL;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      color_d = color_q;
      pg_d    = pg_q;
      scan_d  = scan_q;
      if (!prendido) begin
         state_d = S_OFF;
         rem_d   = '0;
         pg_d    = '0;
         scan_d  = '0;
      end else begin
         case (state_q)
            S_OFF:  state_d = S_IDLE;
            S_IDLE: begin
               if (imprimir && paginas != '0) begin
                  rem_d   = paginas;
                  color_d = color;
                  pg_d    = '0;
                  state_d = ink_ok(color, level_q) ? S_PRINT : S_ERR;
               end else if (escanear) begin
                  scan_d  = SCAN_W'(SCAN_BASE << ajustes_escaner);
                  state_d = S_SCAN;
               end
            end
            S_SCAN: begin
               if (scan_q <= SCAN_W'(1)) begin
                  scan_d  = '0;
                  state_d = S_DONE;
               end else begin
                  scan_d = scan_q - 1'b1;
               end
            end
            S_PRINT: begin
               if (pg_q == PG_LAST) begin
                  pg_d  = '0;
                  rem_d = rem_q - 1'b1;
                  if (rem_q == PAGE_W'(1))       state_d = S_DONE;
                  else if (!ink_ok(color_q, level_d)) state_d = S_ERR;
               end else begin
                  pg_d = pg_q + 1'b1;
               end
            end
            S_ERR: begin
               pg_d = '0;
               if (ink_ok(color_q, level_q)) state_d = S_PRINT;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_OFF;
         endcase
      end
   end

   // Display contents for the upcoming state, so readout tracks rem on the same edge
   always_comb begin
      disp1_d     = '0;
      disp2_d     = '0;
      tens        = 4'(32'(rem_d) / 32'd10);
      units       = 4'(32'(rem_d) % 32'd10);
      empty_found = 1'b0;
      empty_idx   = color_d ? 4'd1 : 4'd0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (!empty_found && is_req(color_d, i) && level_d[i] == '0) begin
            empty_idx   = 4'(i);
            empty_found = 1'b1;
         end
      end
      case (state_d)
         S_IDLE, S_SCAN, S_DONE: begin
            disp1_d = seg(4'd0);
            disp2_d = seg(4'd0);
         end
         S_PRINT: begin
            disp1_d = seg(tens);
            disp2_d = seg(units);
         end
         S_ERR: begin
            disp1_d = SEG_E;
            disp2_d = seg(empty_idx);
         end
         default: begin
            disp1_d = '0;
            disp2_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_OFF;
         rem_q   <= '0;
         color_q <= 1'b0;
         pg_q    <= '0;
         scan_q  <= '0;
         level_q <= {CHANNELS{FULL}};
         esc_q   <= 1'b0;
         imp_q   <= 1'b0;
         err_q   <= 1'b0;
         fin_q   <= 1'b0;
         disp1_q <= '0;
         disp2_q <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         color_q <= color_d;
         pg_q    <= pg_d;
         scan_q  <= scan_d;
         level_q <= level_d;
         esc_q   <= (state_d == S_SCAN);
         imp_q   <= (state_d == S_PRINT);
         err_q   <= (state_d == S_ERR);
         fin_q   <= (state_d == S_DONE);
         disp1_q <= disp1_d;
         disp2_q <= disp2_d;
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < CHANNELS; i++)
         fin_tinta[i] = (level_q[i] == '0);
   end

   assign esc_escaner = esc_q;
   assign imprimiendo = imp_q;
   assign error_tinta = err_q;
   assign fin         = fin_q;
   assign display1    = disp1_q;
   assign display2    = disp2_q;

endmodule

// File: tb/tb_impresora_multitinta.sv
// Directed bench for impresora_multitinta with default parameters.
`timescale 1ns/1ps
module tb_impresora_multitinta;

   logic       clk = 1'b0;
   logic       reset;
   logic       prendido;
   logic       imprimir;
   logic       escanear;
   logic       color;
   logic [3:0] paginas;
   logic [1:0] ajustes_escaner;
   logic [3:0] rellenar;
   logic       esc_escaner;
   logic       imprimiendo;
   logic       error_tinta;
   logic       fin;
   logic [3:0] fin_tinta;
   logic [0:6] display1;
   logic [0:6] display2;

   int passed = 0;
   int total  = 0;

   localparam logic [31:0] D0 = 32'b1111110;
   localparam logic [31:0] D1 = 32'b0110000;
   localparam logic [31:0] D2 = 32'b1101101;
   localparam logic [31:0] D3 = 32'b1111001;
   localparam logic [31:0] DE = 32'b1001111;

   impresora_multitinta dut (
      .clk             (clk),
      .reset           (reset),
      .prendido        (prendido),
      .imprimir        (imprimir),
      .escanear        (escanear),
      .color           (color),
      .paginas         (paginas),
      .ajustes_escaner (ajustes_escaner),
      .rellenar        (rellenar),
      .esc_escaner     (esc_escaner),
      .imprimiendo     (imprimiendo),
      .error_tinta     (error_tinta),
      .fin             (fin),
      .fin_tinta       (fin_tinta),
      .display1        (display1),
      .display2        (display2)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_status(input string tag, input logic [31:0] esc, input logic [31:0] imp,
                             input logic [31:0] err, input logic [31:0] f);
      chk({tag, ".esc"}, 32'(esc_escaner), esc);
      chk({tag, ".imp"}, 32'(imprimiendo), imp);
      chk({tag, ".err"}, 32'(error_tinta), err);
      chk({tag, ".fin"}, 32'(fin), f);
   endtask

   task automatic chk_disp(input string tag, input logic [31:0] d1, input logic [31:0] d2);
      chk({tag, ".d1"}, 32'(display1), d1);
      chk({tag, ".d2"}, 32'(display2), d2);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0; prendido = 1'b0; imprimir = 1'b0; escanear = 1'b0;
      color = 1'b0; paginas = '0; ajustes_escaner = '0; rellenar = '0;
      tick(2);
      chk_status("rst", 0, 0, 0, 0);
      chk_disp("rst", 0, 0);
      chk("rst.fin_tinta", 32'(fin_tinta), 0);

      reset = 1'b1; prendido = 1'b1;
      tick(1);
      chk_disp("idle", D0, D0);
      chk_status("idle", 0, 0, 0, 0);

      // 3-page black job: 12 print cycles, readout 03/02/01
      color = 1'b0; paginas = 4'd3; imprimir = 1'b1;
      tick(1);
      imprimir = 1'b0;
      chk_status("p3.start", 0, 1, 0, 0);
      chk_disp("p3.start", D0, D3);
      tick(3);
      chk_disp("p3.c4", D0, D3);
      tick(1);
      chk_disp("p3.page2", D0, D2);
      tick(4);
      chk_disp("p3.page3", D0, D1);
      tick(3);
      chk("p3.c12.imp", 32'(imprimiendo), 1);
      tick(1);
      chk_status("p3.done", 0, 0, 0, 1);
      chk_disp("p3.done", D0, D0);
      tick(1);
      chk_status("p3.idle", 0, 0, 0, 0);
      chk("p3.fin_tinta", 32'(fin_tinta), 0);

      // Scan with ajustes=3: 16 cycles; mid-scan ajustes change ignored
      ajustes_escaner = 2'd3; escanear = 1'b1;
      tick(1);
      escanear = 1'b0; ajustes_escaner = 2'd0;
      chk_status("scan.start", 1, 0, 0, 0);
      tick(15);
      chk("scan.c16", 32'(esc_escaner), 1);
      tick(1);
      chk_status("scan.done", 0, 0, 0, 1);
      tick(1);
      chk("scan.idle.fin", 32'(fin), 0);
      chk("scan.fin_tinta", 32'(fin_tinta), 0);

      // Second 3-page black job leaves level0 at 1
      paginas = 4'd3; imprimir = 1'b1;
      tick(1);
      imprimir = 1'b0;
      tick(12);
      chk("p3b.done", 32'(fin), 1);
      tick(1);
      chk("p3b.fin_tinta", 32'(fin_tinta), 0);

      // 2-page job runs out after page 1
      paginas = 4'd2; imprimir = 1'b1;
      tick(1);
      imprimir = 1'b0;
      chk_disp("ink.start", D0, D2);
      tick(4);
      chk_status("ink.err", 0, 0, 1, 0);
      chk("ink.fin_tinta", 32'(fin_tinta), 32'b0001);
      chk_disp("ink.err", DE, D0);
      tick(2);
      chk("ink.hold", 32'(error_tinta), 1);
      rellenar = 4'b0001;
      tick(1);
      rellenar = '0;
      chk("ink.refill.fin_tinta", 32'(fin_tinta), 0);
      chk("ink.refill.err", 32'(error_tinta), 1);
      tick(1);
      chk_status("ink.resume", 0, 1, 0, 0);
      chk_disp("ink.resume", D0, D1);
      tick(3);
      chk("ink.c4.imp", 32'(imprimiendo), 1);
      tick(1);
      chk_status("ink.done", 0, 0, 0, 1);
      tick(1);

      // Simultaneous print+scan: print wins
      color = 1'b1; paginas = 4'd1; imprimir = 1'b1; escanear = 1'b1;
      tick(1);
      imprimir = 1'b0; escanear = 1'b0;
      chk_status("both", 0, 1, 0, 0);
      chk_disp("both", D0, D1);
      tick(3);
      chk("both.esc", 32'(esc_escaner), 0);
      tick(1);
      chk("both.done", 32'(fin), 1);
      tick(1);
      paginas = 4'd0; imprimir = 1'b1;
      tick(1);
      imprimir = 1'b0;
      chk_status("zero", 0, 0, 0, 0);
      chk_disp("zero", D0, D0);

      // Power-off mid-scan aborts without fin
      ajustes_escaner = 2'd1; escanear = 1'b1;
      tick(1);
      escanear = 1'b0;
      chk("off.scan", 32'(esc_escaner), 1);
      tick(1);
      prendido = 1'b0;
      tick(1);
      chk_status("off", 0, 0, 0, 0);
      chk_disp("off", 0, 0);
      tick(2);
      chk("off.nofin", 32'(fin), 0);
      prendido = 1'b1;
      tick(1);
      chk_status("on", 0, 0, 0, 0);
      chk_disp("on", D0, D0);

      // Async reset mid-print; levels restored to full
      color = 1'b0; paginas = 4'd5; imprimir = 1'b1;
      tick(1);
      imprimir = 1'b0;
      tick(5);
      chk("mid.imp", 32'(imprimiendo), 1);
      reset = 1'b0;
      #1;
      chk_status("amid", 0, 0, 0, 0);
      chk_disp("amid", 0, 0);
      chk("amid.fin_tinta", 32'(fin_tinta), 0);
      tick(1);
      reset = 1'b1;
      tick(1);
      chk_disp("rst2.idle", D0, D0);
      paginas = 4'd7; imprimir = 1'b1;
      tick(1);
      imprimir = 1'b0;
      tick(27);
      chk("full7.imp", 32'(imprimiendo), 1);
      chk("full7.err", 32'(error_tinta), 0);
      tick(1);
      chk("full7.done", 32'(fin), 1);
      chk("full7.fin_tinta", 32'(fin_tinta), 32'b0001);
      tick(1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
